ps2_command_sequencer: RTL and testbench

PS2_COMMAND_SEQUENCER -- requirements
Module: ps2_command_sequencer

---
 rtl/ps2_command_sequencer_pkg.sv | 30 +++
 rtl/scancode_to_ascii.sv | 60 ++++++
 rtl/ps2_command_sequencer.sv | 160 ++++++++++++++++
 tb/tb_ps2_command_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_command_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ps2_defs
// Shared definitions for the PS/2 command sequencer: FSM state encoding,
// the PS/2 set-2 scancode bytes the sequencer reacts to, the ASCII code
// echoed for a backspace, and the fixed command buffer depth.
// ---------------------------------------------------------------------------
package ps2_defs;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BREAK     = 3'd1,
        ST_EXT       = 3'd2,
        ST_EXT_BREAK = 3'd3,
        ST_ISSUE     = 3'd4
    } state_t;

    // Set-2 scancode bytes with special meaning
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_SPACE = 8'h29;

    // ASCII code sent to the LCD to erase the last character
    localparam logic [7:0] ASCII_BS = 8'h08;

    // Command buffer holds at most four characters
    localparam logic [2:0] LEN_MAX  = 3'd4;

endpackage

// File: rtl/scancode_to_ascii.sv
// ---------------------------------------------------------------------------
// scancode_to_ascii
// Purely combinational PS/2 set-2 make-code to ASCII translation for the
// characters the command line accepts: A-Z, 0-9 and Space.
//
// Ports
//   scancode : in  [7:0] set-2 make code
//   ascii    : out [7:0] ASCII character, 8'h00 when the code is not mapped
// ---------------------------------------------------------------------------
module scancode_to_ascii
    import ps2_defs::*;
(
    input  logic [7:0] scancode,
    output logic [7:0] ascii
);

    always_comb begin
        unique case (scancode)
            8'h1C: ascii = 8'h41; // A
            8'h32: ascii = 8'h42; // B
            8'h21: ascii = 8'h43; // C
            8'h23: ascii = 8'h44; // D
            8'h24: ascii = 8'h45; // E
            8'h2B: ascii = 8'h46; // F
            8'h34: ascii = 8'h47; // G
            8'h33: ascii = 8'h48; // H
            8'h43: ascii = 8'h49; // I
            8'h3B: ascii = 8'h4A; // J
            8'h42: ascii = 8'h4B; // K
            8'h4B: ascii = 8'h4C; // L
            8'h3A: ascii = 8'h4D; // M
            8'h31: ascii = 8'h4E; // N
            8'h44: ascii = 8'h4F; // O
            8'h4D: ascii = 8'h50; // P
            8'h15: ascii = 8'h51; // Q
            8'h2D: ascii = 8'h52; // R
            8'h1B: ascii = 8'h53; // S
            8'h2C: ascii = 8'h54; // T
            8'h3C: ascii = 8'h55; // U
            8'h2A: ascii = 8'h56; // V
            8'h1D: ascii = 8'h57; // W
            8'h22: ascii = 8'h58; // X
            8'h35: ascii = 8'h59; // Y
            8'h1A: ascii = 8'h5A; // Z
            8'h45: ascii = 8'h30; // 0
            8'h16: ascii = 8'h31; // 1
            8'h1E: ascii = 8'h32; // 2
            8'h26: ascii = 8'h33; // 3
            8'h25: ascii = 8'h34; // 4
            8'h2E: ascii = 8'h35; // 5
            8'h36: ascii = 8'h36; // 6
            8'h3D: ascii = 8'h37; // 7
            8'h3E: ascii = 8'h38; // 8
            8'h46: ascii = 8'h39; // 9
            SC_SPACE: ascii = 8'h20;
            default:  ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_command_sequencer.sv
// ---------------------------------------------------------------------------
// ps2_command_sequencer
// Turns a stream of PS/2 set-2 scancode bytes into short typed commands.
// Make codes of A-Z, 0-9 and Space are appended to a 4-character buffer
// (newest character in the low byte) and echoed to the LCD; Backspace drops
// the newest character; Enter hands the buffer to the processor with a
// valid/ready handshake. Break (F0) and extended (E0) sequences are skipped.
//
// Ports
//   clock           : in   sole clock, rising edge
//   reset           : in   asynchronous, active-high
//   ps2_key_pressed : in   one-cycle strobe, new scancode byte
//   ps2_key_data    : in   [7:0] scancode byte, valid with the strobe
//   cmd_ready       : in   processor accepts the pending command
//   cmd_valid       : out  command available (held until accepted)
//   cmd_data        : out  [31:0] packed ASCII, newest char in [7:0]
//   cmd_len         : out  [2:0] number of characters, 0-4
//   overflow        : out  sticky, a fifth character was dropped
//   echo_valid      : out  one-cycle pulse per buffer edit
//   echo_char       : out  [7:0] echoed ASCII, 8'h08 for backspace
// ---------------------------------------------------------------------------
module ps2_command_sequencer
    import ps2_defs::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_key_pressed,
    input  logic [7:0]  ps2_key_data,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [31:0] cmd_data,
    output logic [2:0]  cmd_len,
    output logic        overflow,
    output logic        echo_valid,
    output logic [7:0]  echo_char
);

    state_t      r_state;
    logic [31:0] r_buf;
    logic [2:0]  r_len;
    logic        r_overflow;
    logic        r_echo_valid;
    logic [7:0]  r_echo_char;

    state_t      w_next_state;
    logic [31:0] w_next_buf;
    logic [2:0]  w_next_len;
    logic        w_next_overflow;
    logic        w_next_echo_valid;
    logic [7:0]  w_next_echo_char;
    logic [7:0]  w_ascii;
    logic        w_transfer;

    scancode_to_ascii u_map (
        .scancode (ps2_key_data),
        .ascii    (w_ascii)
    );

    // Decoded straight from the state register so reset clears it at once
    assign cmd_valid  = (r_state == ST_ISSUE);
    assign w_transfer = cmd_valid && cmd_ready;

    // NOTE: every next-state signal gets a default before the case so that
    // no path leaves one unassigned, which would infer a latch.
    always_comb begin
        w_next_state      = r_state;
        w_next_buf        = r_buf;
        w_next_len        = r_len;
        w_next_overflow   = r_overflow;
        w_next_echo_valid = 1'b0;
        w_next_echo_char  = r_echo_char;

        unique case (r_state)
            ST_IDLE: begin
                if (ps2_key_pressed) begin
                    if (ps2_key_data == SC_BREAK) begin
                        w_next_state = ST_BREAK;
                    end else if (ps2_key_data == SC_EXT) begin
                        w_next_state = ST_EXT;
                    end else if (ps2_key_data == SC_ENTER) begin
                        if (r_len != 3'd0) begin
                            w_next_state = ST_ISSUE;
                        end
                    end else if (ps2_key_data == SC_BKSP) begin
                        if (r_len != 3'd0) begin
                            w_next_buf        = {8'h00, r_buf[31:8]};
                            w_next_len        = r_len - 3'd1;
                            w_next_echo_valid = 1'b1;
                            w_next_echo_char  = ASCII_BS;
                        end
                    end else if (w_ascii != 8'h00) begin
                        if (r_len < LEN_MAX) begin
                            w_next_buf        = {r_buf[23:0], w_ascii};
                            w_next_len        = r_len + 3'd1;
                            w_next_echo_valid = 1'b1;
                            w_next_echo_char  = w_ascii;
                        end else begin
                            w_next_overflow = 1'b1;
                        end
                    end
                end
            end

            // The byte after a break prefix is the released key: drop it
            ST_BREAK, ST_EXT_BREAK: begin
                if (ps2_key_pressed) begin
                    w_next_state = ST_IDLE;
                end
            end

            // Extended keys (arrows etc.) are not part of the command set
            ST_EXT: begin
                if (ps2_key_pressed) begin
                    w_next_state = (ps2_key_data == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
                end
            end

            // Keystrokes are discarded while the command waits for pickup
            ST_ISSUE: begin
                if (w_transfer) begin
                    w_next_state    = ST_IDLE;
                    w_next_buf      = 32'h0;
                    w_next_len      = 3'd0;
                    w_next_overflow = 1'b0;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_buf        <= 32'h0;
            r_len        <= 3'd0;
            r_overflow   <= 1'b0;
            r_echo_valid <= 1'b0;
            r_echo_char  <= 8'h00;
        end else begin
            r_state      <= w_next_state;
            r_buf        <= w_next_buf;
            r_len        <= w_next_len;
            r_overflow   <= w_next_overflow;
            r_echo_valid <= w_next_echo_valid;
            r_echo_char  <= w_next_echo_char;
        end
    end

    assign cmd_data   = r_buf;
    assign cmd_len    = r_len;
    assign overflow   = r_overflow;
    assign echo_valid = r_echo_valid;
    assign echo_char  = r_echo_char;

endmodule

// File: tb/tb_ps2_command_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ps2_command_sequencer
// Directed self-checking bench for ps2_command_sequencer. Inputs change on
// the falling clock edge; outputs are sampled on the falling edge, half a
// cycle after the rising edge that updated them.
// ---------------------------------------------------------------------------
module tb_ps2_command_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        ps2_key_pressed;
    logic [7:0]  ps2_key_data;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic [2:0]  cmd_len;
    logic        overflow;
    logic        echo_valid;
    logic [7:0]  echo_char;

    int n_checks = 0;
    int n_errors = 0;
    int n_echo;

    ps2_command_sequencer dut (
        .clock           (clock),
        .reset           (reset),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_key_data    (ps2_key_data),
        .cmd_ready       (cmd_ready),
        .cmd_valid       (cmd_valid),
        .cmd_data        (cmd_data),
        .cmd_len         (cmd_len),
        .overflow        (overflow),
        .echo_valid      (echo_valid),
        .echo_char       (echo_char)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // One-cycle strobe; returns at the falling edge after the capturing
    // rising edge, when the echo for this byte is visible.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        ps2_key_pressed = 1'b1;
        ps2_key_data    = b;
        @(negedge clock);
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
    endtask

    // Send a make code and check the echo it should or should not produce
    task automatic key(input string tag, input logic [7:0] b, input logic exp_echo, input logic [7:0] exp_char);
        send_byte(b);
        check({tag, " echo_valid"}, {31'h0, echo_valid}, {31'h0, exp_echo});
        if (exp_echo) check({tag, " echo_char"}, {24'h0, echo_char}, {24'h0, exp_char});
    endtask

    task automatic transfer();
        @(negedge clock);
        cmd_ready = 1'b1;
        @(negedge clock);
        cmd_ready = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
        cmd_ready       = 1'b0;
        repeat (2) @(negedge clock);

        // ---------------- reset values
        check("rst cmd_valid",  {31'h0, cmd_valid},  32'h0);
        check("rst cmd_data",   cmd_data,            32'h0);
        check("rst cmd_len",    {29'h0, cmd_len},    32'h0);
        check("rst overflow",   {31'h0, overflow},   32'h0);
        check("rst echo_valid", {31'h0, echo_valid}, 32'h0);
        check("rst echo_char",  {24'h0, echo_char},  32'h0);
        reset = 1'b0;
        @(negedge clock);

        // ---------------- typing "AB" with break codes, then Enter
        key("type A",    8'h1C, 1'b1, 8'h41);
        key("type F0",   8'hF0, 1'b0, 8'h00);
        key("type brkA", 8'h1C, 1'b0, 8'h00);
        key("type B",    8'h32, 1'b1, 8'h42);
        key("type F0b",  8'hF0, 1'b0, 8'h00);
        key("type brkB", 8'h32, 1'b0, 8'h00);
        check("type pre-enter valid", {31'h0, cmd_valid}, 32'h0);
        send_byte(8'h5A);
        check("type cmd_valid", {31'h0, cmd_valid}, 32'h1);
        check("type cmd_data",  cmd_data,           32'h0000_4142);
        check("type cmd_len",   {29'h0, cmd_len},   32'd2);
        check("type enter noecho", {31'h0, echo_valid}, 32'h0);

        // ---------------- handshake: stable while not ready
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("hs hold valid", {31'h0, cmd_valid}, 32'h1);
            check("hs hold data",  cmd_data,           32'h0000_4142);
        end
        // Keystrokes in ISSUE, including F0, are dropped
        key("hs key C",    8'h21, 1'b0, 8'h00);
        key("hs key F0",   8'hF0, 1'b0, 8'h00);
        key("hs key bksp", 8'h66, 1'b0, 8'h00);
        key("hs key D",    8'h23, 1'b0, 8'h00);
        check("hs keys valid", {31'h0, cmd_valid}, 32'h1);
        check("hs keys data",  cmd_data,           32'h0000_4142);
        check("hs keys len",   {29'h0, cmd_len},   32'd2);
        // Transfer coinciding with a strobe: transfer wins, byte dropped
        @(negedge clock);
        cmd_ready       = 1'b1;
        ps2_key_pressed = 1'b1;
        ps2_key_data    = 8'h1C;
        @(negedge clock);
        cmd_ready       = 1'b0;
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
        check("hs xfer valid", {31'h0, cmd_valid},  32'h0);
        check("hs xfer len",   {29'h0, cmd_len},    32'd0);
        check("hs xfer data",  cmd_data,            32'h0);
        check("hs xfer echo",  {31'h0, echo_valid}, 32'h0);
        // cmd_ready outside ISSUE has no effect
        cmd_ready = 1'b1;
        repeat (3) @(negedge clock);
        cmd_ready = 1'b0;
        check("hs idle ready", {31'h0, cmd_valid}, 32'h0);

        // ---------------- overflow: A B C D E
        n_echo = 0;
        send_byte(8'h1C); n_echo += int'(echo_valid);
        send_byte(8'h32); n_echo += int'(echo_valid);
        send_byte(8'h21); n_echo += int'(echo_valid);
        check("ovf before 5th", {31'h0, overflow}, 32'h0);
        send_byte(8'h23); n_echo += int'(echo_valid);
        check("ovf 4th echo_char", {24'h0, echo_char}, 32'h44);
        send_byte(8'h24); n_echo += int'(echo_valid);
        check("ovf echo count", n_echo,            32'd4);
        check("ovf data",       cmd_data,          32'h4142_4344);
        check("ovf len",        {29'h0, cmd_len},  32'd4);
        check("ovf flag",       {31'h0, overflow}, 32'h1);
        key("ovf unmapped", 8'h0D, 1'b0, 8'h00);
        check("ovf unmapped data", cmd_data, 32'h4142_4344);
        send_byte(8'h5A);
        check("ovf issue valid", {31'h0, cmd_valid}, 32'h1);
        check("ovf issue flag",  {31'h0, overflow},  32'h1);
        transfer();
        check("ovf xfer flag",   {31'h0, overflow},  32'h0);
        check("ovf xfer data",   cmd_data,           32'h0);

        // ---------------- backspace
        key("bs A", 8'h1C, 1'b1, 8'h41);
        key("bs B", 8'h32, 1'b1, 8'h42);
        key("bs 1", 8'h66, 1'b1, 8'h08);
        check("bs1 data", cmd_data,         32'h0000_0041);
        check("bs1 len",  {29'h0, cmd_len}, 32'd1);
        key("bs 2", 8'h66, 1'b1, 8'h08);
        check("bs2 len",  {29'h0, cmd_len}, 32'd0);
        check("bs2 data", cmd_data,         32'h0);
        key("bs 3 empty", 8'h66, 1'b0, 8'h00);
        send_byte(8'h5A);
        check("bs empty enter", {31'h0, cmd_valid}, 32'h0);
        @(negedge clock);
        check("bs empty enter+1", {31'h0, cmd_valid}, 32'h0);

        // ---------------- prefixes: E0 75, E0 F0 75, then F
        key("pfx E0",   8'hE0, 1'b0, 8'h00);
        key("pfx 75",   8'h75, 1'b0, 8'h00);
        key("pfx E0b",  8'hE0, 1'b0, 8'h00);
        key("pfx F0",   8'hF0, 1'b0, 8'h00);
        key("pfx 75b",  8'h75, 1'b0, 8'h00);
        check("pfx len before F", {29'h0, cmd_len}, 32'd0);
        key("pfx F",    8'h2B, 1'b1, 8'h46);
        check("pfx data", cmd_data,         32'h0000_0046);
        check("pfx len",  {29'h0, cmd_len}, 32'd1);

        // ---------------- reset mid-ISSUE
        key("rst3", 8'h26, 1'b1, 8'h33);
        send_byte(8'h5A);
        check("rstI valid", {31'h0, cmd_valid}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("rstI cmd_valid",  {31'h0, cmd_valid},  32'h0);
        check("rstI cmd_data",   cmd_data,            32'h0);
        check("rstI cmd_len",    {29'h0, cmd_len},    32'h0);
        check("rstI overflow",   {31'h0, overflow},   32'h0);
        check("rstI echo_valid", {31'h0, echo_valid}, 32'h0);
        check("rstI echo_char",  {24'h0, echo_char},  32'h0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rstI after valid", {31'h0, cmd_valid}, 32'h0);
        key("rstI A", 8'h1C, 1'b1, 8'h41);
        check("rstI A data", cmd_data, 32'h0000_0041);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Guard against a stuck simulation
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule
